// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, flush bubbling and
// MEM/WB operand forwarding into the ALU operand muxes.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,

    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_dst,
    input  logic [4:0]  id_shamt,
    input  logic [3:0]  id_alu_ctl,
    input  logic        id_sign,
    input  logic        id_src1_shamt,
    input  logic        id_src2_imm,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,

    input  logic        flush,

    input  logic        mem_reg_write,
    input  logic [4:0]  mem_dst,
    input  logic [31:0] mem_result,
    input  logic        mem_is_load,

    input  logic        wb_reg_write,
    input  logic [4:0]  wb_dst,
    input  logic [31:0] wb_data,

    output logic        stall,

    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_dst,

    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_ctl,
    output logic        alu_sign,
    output logic [31:0] ex_store_data
);

    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_shamt;
    logic        ex_src1_shamt;
    logic        ex_src2_imm;

    logic        hazard;
    logic        bubble;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    // A load in EX cannot supply its data until WB, so a consumer in decode must wait.
    always_comb begin
        hazard = ex_valid & ex_mem_read & (ex_dst != 5'd0) & id_valid &
                 ((id_rs == ex_dst) | (id_rt == ex_dst));
        stall  = hazard & ~flush;
        bubble = flush | stall;
    end

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_pc         <= 32'd0;
            ex_dst        <= 5'd0;
            ex_rs_data    <= 32'd0;
            ex_rt_data    <= 32'd0;
            ex_imm        <= 32'd0;
            ex_rs         <= 5'd0;
            ex_rt         <= 5'd0;
            ex_shamt      <= 5'd0;
            ex_src1_shamt <= 1'b0;
            ex_src2_imm   <= 1'b0;
            alu_ctl       <= 4'd0;
            alu_sign      <= 1'b0;
        end else begin
            ex_valid      <= id_valid;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_pc         <= id_pc;
            ex_dst        <= id_dst;
            ex_rs_data    <= id_rs_data;
            ex_rt_data    <= id_rt_data;
            ex_imm        <= id_imm;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_shamt      <= id_shamt;
            ex_src1_shamt <= id_src1_shamt;
            ex_src2_imm   <= id_src2_imm;
            alu_ctl       <= id_alu_ctl;
            alu_sign      <= id_sign;
        end
    end

    // MEM wins over WB; a load still in MEM has no data yet and is never a source.
    always_comb begin
        fwd_rs = ex_rs_data;
        if (ex_rs != 5'd0) begin
            if (mem_reg_write && !mem_is_load && (mem_dst == ex_rs))
                fwd_rs = mem_result;
            else if (wb_reg_write && (wb_dst == ex_rs))
                fwd_rs = wb_data;
        end
    end

    always_comb begin
        fwd_rt = ex_rt_data;
        if (ex_rt != 5'd0) begin
            if (mem_reg_write && !mem_is_load && (mem_dst == ex_rt))
                fwd_rt = mem_result;
            else if (wb_reg_write && (wb_dst == ex_rt))
                fwd_rt = wb_data;
        end
    end

    always_comb begin
        alu_in1       = ex_src1_shamt ? {27'd0, ex_shamt} : fwd_rs;
        alu_in2       = ex_src2_imm ? ex_imm : fwd_rt;
        ex_store_data = fwd_rt;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, forwarding priority, load-use stall,
// flush/hazard interaction, shift operand and reset behaviour.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_dst, id_shamt;
    logic [3:0]  id_alu_ctl;
    logic        id_sign, id_src1_shamt, id_src2_imm;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        flush;
    logic        mem_reg_write, mem_is_load;
    logic [4:0]  mem_dst;
    logic [31:0] mem_result;
    logic        wb_reg_write;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        stall;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] ex_pc;
    logic [4:0]  ex_dst;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [3:0]  alu_ctl;
    logic        alu_sign;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst), .id_shamt(id_shamt),
        .id_alu_ctl(id_alu_ctl), .id_sign(id_sign), .id_src1_shamt(id_src1_shamt),
        .id_src2_imm(id_src2_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_dst(mem_dst), .mem_result(mem_result),
        .mem_is_load(mem_is_load),
        .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_data(wb_data),
        .stall(stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_pc(ex_pc), .ex_dst(ex_dst),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctl(alu_ctl), .alu_sign(alu_sign),
        .ex_store_data(ex_store_data)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 1'b0; id_pc = 32'd0; id_rs_data = 32'd0; id_rt_data = 32'd0;
        id_imm = 32'd0; id_rs = 5'd0; id_rt = 5'd0; id_dst = 5'd0; id_shamt = 5'd0;
        id_alu_ctl = 4'd0; id_sign = 1'b0; id_src1_shamt = 1'b0; id_src2_imm = 1'b0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    endtask

    task automatic clear_fwd();
        mem_reg_write = 1'b0; mem_dst = 5'd0; mem_result = 32'd0; mem_is_load = 1'b0;
        wb_reg_write = 1'b0; wb_dst = 5'd0; wb_data = 32'd0;
    endtask

    task automatic load_to(input logic [4:0] dst);
        clear_id();
        id_valid = 1'b1; id_rs = 5'd2; id_rs_data = 32'h1000; id_imm = 32'd4;
        id_src2_imm = 1'b1; id_dst = dst; id_reg_write = 1'b1; id_mem_read = 1'b1;
    endtask

    initial begin
        clear_id();
        clear_fwd();
        flush = 1'b0;
        reset = 1'b1;
        // decode slot is busy during reset; reset must still win
        id_valid = 1'b1; id_rs_data = 32'h1234; id_imm = 32'h55; id_reg_write = 1'b1;
        id_mem_write = 1'b1; id_alu_ctl = 4'h7;
        tick();
        tick();
        check_val("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check_val("rst_stall", {31'd0, stall}, 32'd0);
        check_val("rst_alu_in1", alu_in1, 32'd0);
        check_val("rst_alu_in2", alu_in2, 32'd0);
        check_val("rst_store", ex_store_data, 32'd0);
        check_val("rst_ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, alu_sign}, 32'd0);
        check_val("rst_alu_ctl", {28'd0, alu_ctl}, 32'd0);

        // basic capture with immediate operand
        reset = 1'b0;
        clear_id();
        id_valid = 1'b1; id_pc = 32'h100; id_rs = 5'd1; id_rt = 5'd2; id_rs_data = 32'h5;
        id_rt_data = 32'h77; id_imm = 32'h10; id_src2_imm = 1'b1; id_dst = 5'd4; id_reg_write = 1'b1;
        tick();
        check_val("cap_ex_valid", {31'd0, ex_valid}, 32'd1);
        check_val("cap_alu_in1", alu_in1, 32'h5);
        check_val("cap_alu_in2", alu_in2, 32'h10);
        check_val("cap_store", ex_store_data, 32'h77);
        check_val("cap_pc", ex_pc, 32'h100);
        check_val("cap_dst", {27'd0, ex_dst}, 32'd4);
        check_val("cap_reg_write", {31'd0, ex_reg_write}, 32'd1);

        // forwarding priority
        clear_id();
        id_valid = 1'b1; id_pc = 32'h104; id_rs = 5'd3; id_rs_data = 32'h1111; id_rt = 5'd5;
        id_rt_data = 32'h2222; id_alu_ctl = 4'h6; id_sign = 1'b1; id_dst = 5'd6; id_reg_write = 1'b1;
        tick();
        mem_reg_write = 1'b1; mem_dst = 5'd3; mem_result = 32'hAAAA; mem_is_load = 1'b0;
        wb_reg_write = 1'b1; wb_dst = 5'd3; wb_data = 32'hBBBB;
        #1;
        check_val("fwd_mem_prio", alu_in1, 32'hAAAA);
        check_val("fwd_rt_none", alu_in2, 32'h2222);
        check_val("fwd_alu_ctl", {28'd0, alu_ctl}, 32'h6);
        check_val("fwd_alu_sign", {31'd0, alu_sign}, 32'd1);
        mem_reg_write = 1'b0;
        #1;
        check_val("fwd_wb", alu_in1, 32'hBBBB);
        mem_reg_write = 1'b1; mem_is_load = 1'b1;
        #1;
        check_val("fwd_mem_load_skip", alu_in1, 32'hBBBB);
        mem_is_load = 1'b0; mem_dst = 5'd5; wb_reg_write = 1'b0;
        #1;
        check_val("fwd_rs_none", alu_in1, 32'h1111);
        check_val("fwd_rt_mem", alu_in2, 32'hAAAA);
        check_val("fwd_store_mem", ex_store_data, 32'hAAAA);

        // register 0 never forwarded
        clear_fwd();
        clear_id();
        id_valid = 1'b1; id_rs = 5'd0; id_rs_data = 32'd0; id_rt = 5'd0; id_rt_data = 32'h0;
        tick();
        mem_reg_write = 1'b1; mem_dst = 5'd0; mem_result = 32'hFFFF_FFFF;
        wb_reg_write = 1'b1; wb_dst = 5'd0; wb_data = 32'h1234;
        #1;
        check_val("r0_alu_in1", alu_in1, 32'd0);
        check_val("r0_store", ex_store_data, 32'd0);
        clear_fwd();

        // load-use stall: load to $8 then consumer of $8
        load_to(5'd8);
        tick();
        check_val("lu_ex_mem_read", {31'd0, ex_mem_read}, 32'd1);
        check_val("lu_load_addr", alu_in1 + alu_in2, 32'h1004);
        clear_id();
        id_valid = 1'b1; id_rs = 5'd9; id_rs_data = 32'h3; id_rt = 5'd8; id_rt_data = 32'hDEAD;
        id_dst = 5'd10; id_reg_write = 1'b1;
        #1;
        check_val("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        check_val("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        check_val("lu_bubble_in1", alu_in1, 32'd0);
        check_val("lu_bubble_in2", alu_in2, 32'd0);
        check_val("lu_stall_clear", {31'd0, stall}, 32'd0);
        mem_reg_write = 1'b1; mem_is_load = 1'b1; mem_dst = 5'd8; mem_result = 32'h1004;
        #1;
        check_val("lu_bubble_fwd_zero", alu_in2, 32'd0);
        clear_fwd();
        tick();
        wb_reg_write = 1'b1; wb_dst = 5'd8; wb_data = 32'h5555;
        #1;
        check_val("lu_consumer_valid", {31'd0, ex_valid}, 32'd1);
        check_val("lu_consumer_dst", {27'd0, ex_dst}, 32'd10);
        check_val("lu_consumer_in1", alu_in1, 32'h3);
        check_val("lu_consumer_wb_fwd", alu_in2, 32'h5555);
        clear_fwd();

        // flush together with a load-use hazard
        load_to(5'd7);
        tick();
        clear_id();
        id_valid = 1'b1; id_rs = 5'd7; id_rs_data = 32'h42; id_mem_write = 1'b1;
        flush = 1'b1;
        #1;
        check_val("fl_stall", {31'd0, stall}, 32'd0);
        tick();
        flush = 1'b0;
        check_val("fl_ex_valid", {31'd0, ex_valid}, 32'd0);
        check_val("fl_mem_write", {31'd0, ex_mem_write}, 32'd0);
        check_val("fl_alu_in1", alu_in1, 32'd0);

        // shift-amount operand
        clear_id();
        id_valid = 1'b1; id_src1_shamt = 1'b1; id_shamt = 5'd4; id_rs = 5'd1; id_rs_data = 32'h99;
        id_rt = 5'd2; id_rt_data = 32'h1; id_alu_ctl = 4'h3;
        tick();
        check_val("sh_alu_in1", alu_in1, 32'h4);
        check_val("sh_alu_in2", alu_in2, 32'h1);

        // load to $0 never stalls
        load_to(5'd0);
        tick();
        clear_id();
        id_valid = 1'b1; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        check_val("r0_no_stall", {31'd0, stall}, 32'd0);

        // hazard indices match but decode slot empty: no stall
        load_to(5'd8);
        tick();
        clear_id();
        id_valid = 1'b0; id_rt = 5'd8;
        #1;
        check_val("inv_no_stall", {31'd0, stall}, 32'd0);

        // reset during a stall
        id_valid = 1'b1; id_rs = 5'd9; id_rs_data = 32'h3; id_dst = 5'd10; id_reg_write = 1'b1;
        #1;
        check_val("rs_stall_before", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        tick();
        check_val("rs_ex_valid", {31'd0, ex_valid}, 32'd0);
        check_val("rs_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;
        tick();
        check_val("rs_capture_valid", {31'd0, ex_valid}, 32'd1);
        check_val("rs_capture_dst", {27'd0, ex_dst}, 32'd10);
        check_val("rs_capture_in1", alu_in1, 32'h3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-003 id_valid  in  1  decode slot holds a real instruction.
REQ-004 id_pc, id_rs_data, id_rt_data, id_imm  in  32 each  PC, register-file reads, extended immediate.
REQ-005 id_rs, id_rt, id_dst, id_shamt  in  5 each  source indices, destination index, shift amount.
REQ-006 id_alu_ctl  in  4 / id_sign  in  1  ALU operation code and signed-compare flag.
REQ-007 id_src1_shamt, id_src2_imm, id_reg_write, id_mem_read, id_mem_write  in  1 each  operand selects and controls.
REQ-008 flush  in  1  kill the decode-slot instruction (taken branch/jump).
REQ-009 mem_reg_write  in  1 / mem_dst  in  5 / mem_result  in  32 / mem_is_load  in  1  MEM-stage writeback info.
REQ-010 wb_reg_write  in  1 / wb_dst  in  5 / wb_data  in  32  WB-stage writeback info.
REQ-011 stall  out  1  freeze PC and IF/ID this cycle.
REQ-012 ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered EX controls.
REQ-013 ex_pc  out  32 / ex_dst  out  5  registered PC and destination.
REQ-014 alu_in1, alu_in2  out  32 / alu_ctl  out  4 / alu_sign  out  1  ALU operands and controls.
REQ-015 ex_store_data  out  32  forwarded rt value for stores.

Function
REQ-016 On each rising edge the stage SHALL capture all id_* fields into its EX register unless a bubble is inserted.
REQ-017 Bubble SHALL be inserted when flush=1 or stall=1: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write = 0; all other fields = 0.
REQ-018 Load-use hazard = ex_valid & ex_mem_read & ex_dst!=0 & id_valid & (id_rs==ex_dst | id_rt==ex_dst).
REQ-019 stall SHALL equal hazard & ~flush (combinational, same cycle); flush with hazard yields bubble, no stall.
REQ-020 Forwarded rs value: registered rs index ==0 -> registered rs data; else mem_reg_write & ~mem_is_load & mem_dst==rs -> mem_result; else wb_reg_write & wb_dst==rs -> wb_data; else registered rs data. Same rule for rt.
REQ-021 MEM-stage match SHALL take priority over WB-stage match; index 0 SHALL never be forwarded.
REQ-022 alu_in1 = src1_shamt ? {27'b0, shamt} : forwarded rs; alu_in2 = src2_imm ? imm : forwarded rt.
REQ-023 ex_store_data SHALL always be forwarded rt, independent of src2_imm.
REQ-024 alu_ctl, alu_sign SHALL be the registered id_alu_ctl, id_sign; bubble gives alu_ctl=0 (add), sign=0.
REQ-025 Forwarding and operand muxes SHALL be combinational from registered fields and mem_*/wb_* inputs; zero added latency.
REQ-026 Instruction latency through the stage SHALL be exactly one cycle; a stalled instruction enters EX the cycle after stall deasserts.
REQ-027 Forwarding SHALL apply even when ex_valid=0 only through zeroed indices, i.e. bubbles produce alu_in1=alu_in2=0.

Reset
REQ-028 reset=1 SHALL load the bubble state of REQ-017; takes priority over flush, stall and capture.
REQ-029 After reset: stall=0, alu_in1=alu_in2=ex_store_data=0, all EX controls 0.
REQ-030 Reset asserted mid-stall SHALL discard the stalled situation; first post-reset edge with id_valid=1 captures normally.

Verification
REQ-031 Capture: id_rs_data=0x5, id_imm=0x10, src2_imm=1, alu_ctl=0 -> next cycle ex_valid=1, alu_in1=0x5, alu_in2=0x10.
REQ-032 Forward priority: rs=3, mem_dst=3 result 0xAAAA, wb_dst=3 data 0xBBBB, both writes=1 -> alu_in1=0xAAAA; mem_reg_write=0 -> 0xBBBB.
REQ-033 Register 0: rs=0, mem_dst=0, mem_result=0xFFFF_FFFF -> alu_in1=registered rs data (0).
REQ-034 Load-use: EX holds load to $8, decode uses rt=$8 -> stall=1 one cycle, next EX is bubble, following cycle consumer enters EX and forwards wb_data.
REQ-035 Flush vs hazard: hazard and flush same cycle -> stall=0, next ex_valid=0, ex_mem_write=0.
REQ-036 Shift: src1_shamt=1, shamt=4, rt data 0x1 -> alu_in1=0x4, alu_in2=0x1.
